mux_rr_arbiter: RTL and testbench

Four-requester round-robin arbiter that owns the 2-bit select of the shared 4:1 bit mux (inputs a/b/c/d selected by sel 00/01/10/11). Requesters raise a level request for as long as they need the mux. The arbiter grants one requester at a time, drives the mux select, and bounds each tenure with a hold counter so no requester can starve the others. It sits between the requester logic and the mux; `sel_o` connects directly to the mux `sel_i`.

---
 rtl/mux_rr_arbiter.sv | 105 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing a 4:1 bit mux.
// It grants one requester at a time, and a hold counter bounds each tenure while others wait.
module mux_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o,
  output logic [1:0] sel_o,
  output logic       busy_o,
  output logic       preempt_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  state_t     state;
  logic [7:0] count;
  logic [1:0] ptr;

  logic       owner_req;
  logic [3:0] others;
  logic [1:0] next_any;
  logic [1:0] next_other;

  // The search starts just after the last owner and wraps mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign owner_req  = req_i[sel_o];
  assign others     = req_i & ~gnt_o;
  assign next_any   = rr_pick(req_i, ptr);
  assign next_other = rr_pick(others, ptr);

  // A release is checked before expiry, so a release on the expiry cycle never pulses preempt.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      gnt_o     <= 4'b0000;
      sel_o     <= 2'b00;
      busy_o    <= 1'b0;
      preempt_o <= 1'b0;
      count     <= 8'd0;
      ptr       <= 2'd3;
    end else begin
      preempt_o <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_i) begin
            state  <= GRANT;
            gnt_o  <= 4'(1) << next_any;
            sel_o  <= next_any;
            ptr    <= next_any;
            busy_o <= 1'b1;
            count  <= 8'd1;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            if (|others) begin
              gnt_o <= 4'(1) << next_other;
              sel_o <= next_other;
              ptr   <= next_other;
              count <= 8'd1;
            end else begin
              state  <= IDLE;
              gnt_o  <= 4'b0000;
              busy_o <= 1'b0;
              count  <= 8'd0;
            end
          end else if (count >= HOLD_LIM) begin
            if (|others) begin
              gnt_o     <= 4'(1) << next_other;
              sel_o     <= next_other;
              ptr       <= next_other;
              count     <= 8'd1;
              preempt_o <= 1'b1;
            end else begin
              count <= HOLD_LIM;
            end
          end else begin
            count <= count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed, table-driven bench for mux_rr_arbiter with HOLD_MAX = 4.
// It also runs hand-written sequences for saturation, release at expiry and asynchronous reset.
module tb_mux_rr_arbiter;

  logic       clk_i;
  logic       rst_i;
  logic [3:0] req_i;
  logic [3:0] gnt_o;
  logic [1:0] sel_o;
  logic       busy_o;
  logic       preempt_o;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic       rst_first;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       pre;
  } vec_t;

  vec_t vecs[$];

  mux_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .sel_o    (sel_o),
    .busy_o   (busy_o),
    .preempt_o(preempt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [3:0] gnt, input logic [1:0] sel,
                             input logic busy, input logic pre);
    tests_run++;
    if (gnt_o !== gnt || sel_o !== sel || busy_o !== busy || preempt_o !== pre) begin
      tests_failed++;
      $display("[TB] FAIL %s: got gnt=%b sel=%b busy=%b pre=%b, expected gnt=%b sel=%b busy=%b pre=%b",
               name, gnt_o, sel_o, busy_o, preempt_o, gnt, sel, busy, pre);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic applyStimulus(input logic [3:0] req);
    @(negedge clk_i);
    req_i = req;
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_i = 1'b1;
    req_i = 4'b0000;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_i        = 1'b1;
    req_i        = 4'b0000;

    // Rotation on release, with each owner holding its request for two cycles.
    vecs.push_back('{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0});
    // Preemption with req 0011 held constant, starting from a fresh reset.
    vecs.push_back('{1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0});
    // A non-owner request vanishing does not disturb the owner.
    vecs.push_back('{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0});

    #12;
    checkOutput("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_first) doReset();
      applyStimulus(vecs[i].req);
      checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].pre);
    end

    // Saturation with a lone requester, followed by a release to idle.
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b0100);
      checkOutput($sformatf("sat_cycle%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    applyStimulus(4'b0000);
    checkOutput("sat_release_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // A contender arriving after saturation triggers an immediate preemption.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(4'b0100);
    checkOutput("sat_before_contender", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0101);
    checkOutput("sat_contender_preempt", 4'b0001, 2'd0, 1'b1, 1'b1);

    // The owner releases on the same edge its count reaches HOLD_MAX, so no preempt pulse.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(4'b0011);
    checkOutput("expiry_owner_at_max", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0010);
    checkOutput("release_at_expiry", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Asynchronous reset while gnt is 1000.
    doReset();
    applyStimulus(4'b1000);
    checkOutput("pre_reset_owner3", 4'b1000, 2'd3, 1'b1, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("async_reset_mid_tenure", 4'b0000, 2'd0, 1'b0, 1'b0);
    req_i = 4'b1001;
    @(negedge clk_i);
    rst_i = 1'b0;
    applyStimulus(4'b1001);
    checkOutput("first_grant_after_reset", 4'b0001, 2'd0, 1'b1, 1'b0);

    // The pointer must return to 3 even when the owner before reset was requester 1.
    doReset();
    applyStimulus(4'b0010);
    checkOutput("pre_reset_owner1", 4'b0010, 2'd1, 1'b1, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("async_reset_owner1", 4'b0000, 2'd0, 1'b0, 1'b0);
    req_i = 4'b1001;
    @(negedge clk_i);
    rst_i = 1'b0;
    applyStimulus(4'b1001);
    checkOutput("pointer_reset", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
